bp_io_cmd_credit_gate: RTL and testbench
========================================

BP_IO_CMD_CREDIT_GATE -- requirements
Module: bp_io_cmd_credit_gate

Interface
REQ-001 Parameter msg_width_p, default 512: width of the IO memory message, header plus data, in bits.
REQ-002 Parameter max_credits_p, default 32: maximum number of IO commands in flight to the downstream host.
REQ-003 Parameter timeout_cycles_p, default 1024: number of cycles without a response, while commands are in flight, before a timeout is flagged.
REQ-004 Port clk_i, input, 1 bit: the single clock.
REQ-005 Port reset_i, input, 1 bit: reset, synchronous and active-high.
REQ-006 Port io_cmd_i, input, msg_width_p bits: command from the core side.
REQ-007 Port io_cmd_v_i, input, 1 bit: command valid.
REQ-008 Port io_cmd_ready_o, output, 1 bit: command accepted (ready/valid).
REQ-009 Port io_cmd_o, output, msg_width_p bits: command to the host.
REQ-010 Port io_cmd_v_o, output, 1 bit: command valid toward the host.
REQ-011 Port io_cmd_ready_i, input, 1 bit: host ready.
REQ-012 Port io_resp_i, input, msg_width_p bits: response from the host.
REQ-013 Port io_resp_v_i, input, 1 bit: response valid.
REQ-014 Port io_resp_yumi_o, output, 1 bit: response consumed.
REQ-015 Port io_resp_o, output, msg_width_p bits: response to the core side.
REQ-016 Port io_resp_v_o, output, 1 bit: response valid to the core side.
REQ-017 Port io_resp_yumi_i, input, 1 bit: core consumed the response.
REQ-018 Port drain_i, input, 1 bit: request to stop issuing and drain.
REQ-019 Port drained_o, output, 1 bit: no commands are outstanding and issue is stopped.
REQ-020 Port timeout_o, output, 1 bit: sticky watchdog flag.
REQ-021 Port underflow_o, output, 1 bit: sticky flag for a response arriving with no credit in flight.
REQ-022 Port outstanding_o, output, clog2(max_credits_p+1) bits: current in-flight count.

Function
REQ-023 The block SHALL drive io_cmd_o from io_cmd_i combinationally, with no storage and zero latency.
REQ-024 The block SHALL derive gate = (state==RUN) & (outstanding < max_credits_p).
REQ-025 The block SHALL drive io_cmd_v_o = io_cmd_v_i & gate and io_cmd_ready_o = io_cmd_ready_i & gate.
REQ-026 The response path SHALL be a combinational pass-through: io_resp_o = io_resp_i, io_resp_v_o = io_resp_v_i, io_resp_yumi_o = io_resp_yumi_i.
REQ-027 The block SHALL define cmd_fire = io_cmd_v_o & io_cmd_ready_i and resp_fire = io_resp_v_i & io_resp_yumi_i.
REQ-028 The outstanding counter SHALL update each cycle:
- +1 on cmd_fire only.
- -1 on resp_fire only.
- Unchanged when both fire or neither fires.
REQ-029 The counter SHALL never exceed max_credits_p, which the gate guarantees.
REQ-030 At the limit, a same-cycle resp_fire SHALL NOT re-open the gate until the next cycle.
REQ-031 If resp_fire occurs with outstanding==0 and no same-cycle cmd_fire:
- The counter SHALL hold at 0 (no wrap).
- underflow_o SHALL set and stay set until reset.
REQ-032 The watchdog counter SHALL clear on resp_fire or when outstanding==0.
REQ-033 The watchdog counter SHALL otherwise increment, saturating at timeout_cycles_p-1.
REQ-034 timeout_o SHALL set the cycle after the watchdog reaches timeout_cycles_p-1 and stay set until reset.
REQ-035 The FSM SHALL have three states: RUN, DRAIN and DONE.
REQ-036 FSM transitions:
- RUN -> DRAIN when drain_i=1.
- DRAIN -> DONE when outstanding==0 and no resp_fire is pending that cycle.
- DONE -> RUN when drain_i=0.
- All other conditions hold the current state.
REQ-037 drained_o SHALL be 1 only in DONE.
REQ-038 In DRAIN and DONE, commands SHALL be blocked (gate=0) while responses still pass through.
REQ-039 A command that fires in the same cycle drain_i rises SHALL be counted and SHALL be drained before DONE is reached.

Reset
REQ-040 While reset_i is high at a clock edge, the block SHALL set:
- state = RUN
- outstanding = 0
- watchdog = 0
- timeout_o = 0
- underflow_o = 0
- drained_o = 0
REQ-041 A reset mid-operation SHALL discard all in-flight accounting; commands outstanding at reset are not tracked afterwards.
REQ-042 During reset, io_cmd_v_o and io_cmd_ready_o SHALL follow the post-reset gate of RUN with count 0, so they pass through io_cmd_v_i and io_cmd_ready_i.

Verification
REQ-043 Credit limit: with max_credits_p=4, hold io_cmd_v_i=1 and io_cmd_ready_i=1 with no responses for 6 cycles -> exactly 4 commands fire, outstanding_o=4, and io_cmd_ready_o=0 from cycle 5.
REQ-044 Simultaneous fire: at outstanding=3, cmd_fire and resp_fire in the same cycle -> outstanding stays 3; at outstanding=4, a resp_fire alone -> 3, and the gate reopens the next cycle.
REQ-045 Drain: at outstanding=2, pulse drain_i high and hold it -> io_cmd_v_o=0 immediately; after two responses, drained_o=1 the cycle after the count reaches 0; lower drain_i -> RUN, and commands flow next cycle.
REQ-046 Timeout: with timeout_cycles_p=16, issue 1 command and send no response -> timeout_o=1 after 16 cycles and stays 1 after a later response.
REQ-047 Underflow: with outstanding=0, inject io_resp_v_i=1 and io_resp_yumi_i=1 -> underflow_o=1 and outstanding_o stays 0.
REQ-048 Reset mid-flight: at outstanding=3 with timeout_o=1, assert reset_i for 1 cycle -> all counters and flags are 0 and the state is RUN.

Source files
------------

// File: rtl/bp_io_cmd_credit_gate.sv
// bp_io_cmd_credit_gate: credit-limited IO command gate with drain control,
// in-flight watchdog and response-underflow detection.
module bp_io_cmd_credit_gate #(
  parameter int msg_width_p      = 512,
  parameter int max_credits_p    = 32,
  parameter int timeout_cycles_p = 1024
) (
  input  logic                                 clk_i,
  input  logic                                 reset_i,
  input  logic [msg_width_p-1:0]               io_cmd_i,
  input  logic                                 io_cmd_v_i,
  output logic                                 io_cmd_ready_o,
  output logic [msg_width_p-1:0]               io_cmd_o,
  output logic                                 io_cmd_v_o,
  input  logic                                 io_cmd_ready_i,
  input  logic [msg_width_p-1:0]               io_resp_i,
  input  logic                                 io_resp_v_i,
  output logic                                 io_resp_yumi_o,
  output logic [msg_width_p-1:0]               io_resp_o,
  output logic                                 io_resp_v_o,
  input  logic                                 io_resp_yumi_i,
  input  logic                                 drain_i,
  output logic                                 drained_o,
  output logic                                 timeout_o,
  output logic                                 underflow_o,
  output logic [$clog2(max_credits_p+1)-1:0]   outstanding_o
);
  localparam int cw = $clog2(max_credits_p+1);
  localparam int ww = $clog2(timeout_cycles_p+1);
  localparam logic [cw-1:0] max_c  = cw'(max_credits_p);
  localparam logic [ww-1:0] wd_max = ww'(timeout_cycles_p-1);
  localparam logic [1:0] run_s   = 2'd0;
  localparam logic [1:0] drain_s = 2'd1;
  localparam logic [1:0] done_s  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [cw-1:0] cnt_q, cnt_d;
  logic [ww-1:0] wd_q, wd_d;
  logic          timeout_q, timeout_d;
  logic          underflow_q, underflow_d;
  logic          gate, cmd_fire, resp_fire, resp_only, cnt_zero;

  // Reset forces the gate open so the handshake behaves as RUN with no credits used.
  assign gate      = reset_i | ((state_q == run_s) & (cnt_q < max_c));
  assign io_cmd_o       = io_cmd_i;
  assign io_cmd_v_o     = io_cmd_v_i & gate;
  assign io_cmd_ready_o = io_cmd_ready_i & gate;
  assign io_resp_o      = io_resp_i;
  assign io_resp_v_o    = io_resp_v_i;
  assign io_resp_yumi_o = io_resp_yumi_i;
  assign cmd_fire  = io_cmd_v_o & io_cmd_ready_i;
  assign resp_fire = io_resp_v_i & io_resp_yumi_i;
  assign resp_only = resp_fire & ~cmd_fire;
  assign cnt_zero  = (cnt_q == '0);

  always_comb begin
    cnt_d       = (cmd_fire & ~resp_fire) ? cnt_q + 1'b1 :
                  (resp_only & ~cnt_zero) ? cnt_q - 1'b1 : cnt_q;
    underflow_d = underflow_q | (resp_only & cnt_zero);
    wd_d        = (resp_fire | cnt_zero) ? '0 :
                  (wd_q == wd_max) ? wd_q : wd_q + 1'b1;
    timeout_d   = timeout_q | (wd_q == wd_max);
    state_d     = (state_q == run_s)   ? (drain_i ? drain_s : run_s) :
                  (state_q == drain_s) ? ((cnt_zero & ~resp_fire) ? done_s : drain_s) :
                  (drain_i ? done_s : run_s);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= run_s;
      cnt_q       <= '0;
      wd_q        <= '0;
      timeout_q   <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wd_q        <= wd_d;
      timeout_q   <= timeout_d;
      underflow_q <= underflow_d;
    end
  end

  assign drained_o     = (state_q == done_s);
  assign timeout_o     = timeout_q;
  assign underflow_o   = underflow_q;
  assign outstanding_o = cnt_q;
endmodule

// File: tb/tb_bp_io_cmd_credit_gate.sv
// tb_bp_io_cmd_credit_gate: table-driven check of credit gating, drain,
// underflow, plus hand sequences for watchdog timeout and mid-flight reset.
module tb_bp_io_cmd_credit_gate;
  localparam int mw = 16;

  typedef struct {
    logic [5:0] in;
    logic [1:0] ecmd;
    int         eout;
    logic [2:0] eflg;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst, cv, cr, rv, ry, dr;
  logic [mw-1:0] cmd_d, resp_d;
  logic [mw-1:0] cmd_o, resp_o;
  logic          cv_o, cr_o, rv_o, ry_o, drn_o, to_o, uf_o;
  logic [2:0]    out_o;
  int            n_vec = 0;
  int            n_err = 0;
  vec_t          vecs[30];

  always #5 clk = ~clk;

  bp_io_cmd_credit_gate #(.msg_width_p(mw), .max_credits_p(4), .timeout_cycles_p(16)) dut (
    .clk_i(clk), .reset_i(rst),
    .io_cmd_i(cmd_d), .io_cmd_v_i(cv), .io_cmd_ready_o(cr_o),
    .io_cmd_o(cmd_o), .io_cmd_v_o(cv_o), .io_cmd_ready_i(cr),
    .io_resp_i(resp_d), .io_resp_v_i(rv), .io_resp_yumi_o(ry_o),
    .io_resp_o(resp_o), .io_resp_v_o(rv_o), .io_resp_yumi_i(ry),
    .drain_i(dr), .drained_o(drn_o), .timeout_o(to_o), .underflow_o(uf_o),
    .outstanding_o(out_o)
  );

  function automatic vec_t mk(input logic [5:0] in, input logic [1:0] ecmd, input int eout,
                              input logic [2:0] eflg);
    vec_t v;
    v.in = in; v.ecmd = ecmd; v.eout = eout; v.eflg = eflg;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s [%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  initial begin
    // in = {reset, cmd_v, cmd_ready, resp_v, resp_yumi, drain}; flags = {drained, timeout, underflow}
    vecs[0]  = mk(6'b111000, 2'b11, 0, 3'b000);
    vecs[1]  = mk(6'b011000, 2'b11, 0, 3'b000);
    vecs[2]  = mk(6'b011000, 2'b11, 1, 3'b000);
    vecs[3]  = mk(6'b011000, 2'b11, 2, 3'b000);
    vecs[4]  = mk(6'b011000, 2'b11, 3, 3'b000);
    vecs[5]  = mk(6'b011000, 2'b00, 4, 3'b000);
    vecs[6]  = mk(6'b011000, 2'b00, 4, 3'b000);
    vecs[7]  = mk(6'b001110, 2'b00, 4, 3'b000);
    vecs[8]  = mk(6'b011110, 2'b11, 3, 3'b000);
    vecs[9]  = mk(6'b001000, 2'b01, 3, 3'b000);
    vecs[10] = mk(6'b011000, 2'b11, 3, 3'b000);
    vecs[11] = mk(6'b011110, 2'b00, 4, 3'b000);
    vecs[12] = mk(6'b011000, 2'b11, 3, 3'b000);
    vecs[13] = mk(6'b010100, 2'b00, 4, 3'b000);
    vecs[14] = mk(6'b000110, 2'b00, 4, 3'b000);
    vecs[15] = mk(6'b000110, 2'b00, 3, 3'b000);
    vecs[16] = mk(6'b011001, 2'b11, 2, 3'b000);
    vecs[17] = mk(6'b011001, 2'b00, 3, 3'b000);
    vecs[18] = mk(6'b011111, 2'b00, 3, 3'b000);
    vecs[19] = mk(6'b000111, 2'b00, 2, 3'b000);
    vecs[20] = mk(6'b000111, 2'b00, 1, 3'b000);
    vecs[21] = mk(6'b011001, 2'b00, 0, 3'b000);
    vecs[22] = mk(6'b011001, 2'b00, 0, 3'b100);
    vecs[23] = mk(6'b011000, 2'b00, 0, 3'b100);
    vecs[24] = mk(6'b011000, 2'b11, 0, 3'b000);
    vecs[25] = mk(6'b000110, 2'b00, 1, 3'b000);
    vecs[26] = mk(6'b001110, 2'b01, 0, 3'b000);
    vecs[27] = mk(6'b000000, 2'b00, 0, 3'b001);
    vecs[28] = mk(6'b011110, 2'b11, 0, 3'b001);
    vecs[29] = mk(6'b000000, 2'b00, 0, 3'b001);
    {rst, cv, cr, rv, ry, dr} = 6'b100000;
    cmd_d = '0; resp_d = '0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 30; i++) begin
      {rst, cv, cr, rv, ry, dr} = vecs[i].in;
      cmd_d  = mw'($urandom);
      resp_d = mw'($urandom);
      #1;
      check("cmd_v_o", i, 32'(cv_o), 32'(vecs[i].ecmd[1]));
      check("cmd_ready_o", i, 32'(cr_o), 32'(vecs[i].ecmd[0]));
      check("outstanding", i, 32'(out_o), 32'(vecs[i].eout));
      check("flags", i, 32'({drn_o, to_o, uf_o}), 32'(vecs[i].eflg));
      check("cmd_data", i, 32'(cmd_o), 32'(cmd_d));
      check("resp_path", i, 32'({resp_o, rv_o, ry_o}), 32'({resp_d, rv, ry}));
      @(negedge clk);
    end
    // watchdog: one command, no response
    {rst, cv, cr, rv, ry, dr} = 6'b011000;
    @(negedge clk);
    {cv, cr} = 2'b00;
    repeat (15) @(negedge clk);
    #1 check("timeout_early", 100, 32'(to_o), 32'd0);
    @(negedge clk);
    #1 check("timeout_set", 101, 32'(to_o), 32'd1);
    check("timeout_out", 102, 32'(out_o), 32'd1);
    {rv, ry} = 2'b11;
    @(negedge clk);
    {rv, ry} = 2'b00;
    #1 check("timeout_sticky", 103, 32'(to_o), 32'd1);
    check("timeout_resp_out", 104, 32'(out_o), 32'd0);
    // reset mid-flight while draining with timeout flagged
    {cv, cr} = 2'b11;
    repeat (3) @(negedge clk);
    {cv, cr} = 2'b00;
    #1 check("pre_reset_out", 105, 32'(out_o), 32'd3);
    dr = 1'b1;
    @(negedge clk);
    dr = 1'b0;
    {cv, cr} = 2'b11;
    #1 check("drain_block", 106, 32'({cv_o, cr_o}), 32'd0);
    rst = 1'b1;
    #1 check("reset_gate_open", 107, 32'({cv_o, cr_o}), 32'd3);
    @(negedge clk);
    rst = 1'b0;
    {cv, cr} = 2'b00;
    #1 check("reset_clear", 108, 32'({out_o, drn_o, to_o, uf_o}), 32'd0);
    {cv, cr} = 2'b11;
    #1 check("reset_run", 109, 32'({cv_o, cr_o}), 32'd3);
    @(negedge clk);
    {cv, cr} = 2'b00;
    #1 check("post_reset_count", 110, 32'(out_o), 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
